decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I/RV32M instruction-decode stage sitting between fetch and execute. It accepts (ir, pc) pairs over a valid/ready handshake and decodes them into operand, immediate, ALU-code and control fields, using the `define.vh` opcode and ALU-code encodings. Results are buffered in a DEPTH-entry FIFO so execute stalls do not immediately stall fetch. New relative to the plain combinational decoder: optional M-extension decode, illegal-instruction and ECALL/EBREAK detection, and a synchronous flush for branch redirect.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- ENABLE_M, 0: 1 decodes the RV32M funct7=0000001 OP group into ALU_MUL…ALU_REMU (new `define.vh` codes); 0 flags that group illegal.
- clk  in  1  clock. Only clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (branch redirect).
- in_valid / in_ready  in / out  1 / 1  fetch handshake.
- in_ir, in_pc  in  32 each  instruction word and its PC.
- out_valid / out_ready  out / in  1 / 1  execute handshake.
- out_pc  out  32  PC of the head entry.
- srcreg1_num, srcreg2_num, dstreg_num  out  5 each  register numbers.
- imm  out  32  extended immediate.
- alucode  out  6; aluop1_type, aluop2_type  out  2 each.
- reg_we, is_load, is_store, is_halt, illegal  out  1 each.
- count  out  $clog2(DEPTH+1)  occupancy.

## Operation
- Decode is combinational on in_ir. Each FIFO entry stores pc plus all decoded fields.
- Field encoding:
  - U, J, B, I, S immediates are sign-extended per RV32I; LOAD imm = {{20{ir[31]}}, ir[31:20]}.
  - Shift-immediate imm = zero-extended ir[24:20].
  - Unused register fields are 0.
- reg_we = 1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP (including M when enabled), and only when rd ≠ 0.
- is_load = 1 for LOAD. is_store = 1 for STORE.
- is_halt = 1 for SYSTEM opcode 1110011 with ir[31:7] = 0 (ECALL) or 0x00002000>>7 pattern (EBREAK, imm = 1). is_halt keeps reg_we = 0.
- illegal = 1 in each of these cases; all other decoded fields are then 0:
  - unknown opcode;
  - reserved funct3 (BRANCH 010/011, LOAD 011/110/111, STORE ≥011);
  - OP with funct7 not in {0000000, 0100000, 0000001 when ENABLE_M};
  - SYSTEM other than ECALL/EBREAK.
- An illegal instruction is still enqueued, so the pipeline can trap on it.
- Push occurs when in_valid & in_ready & !flush. Pop occurs when out_valid & out_ready & !flush.
- Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH), a combinational function of state only, not of out_ready. A push at full is refused even if a pop happens in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- out_valid = (count ≠ 0). When out_valid = 0, all decoded output fields and out_pc are 0.
- flush = 1: at the next edge count, rd_ptr and wr_ptr become 0. Any push or pop in that cycle is discarded. flush has priority over all other actions.

## Timing
- Latency: a word accepted at edge N appears on the outputs from cycle N+1 (after the edge), provided the FIFO was empty.
- Throughput: 1 instruction per cycle when out_ready = 1 continuously.
- Reset (rst_n = 0, asynchronous):
  - count and pointers clear immediately;
  - out_valid and all output fields become 0;
  - in_ready = 1.
- Reset asserted mid-operation drops all entries with no partial outputs. The first push after rst_n rises is accepted on the first edge.
- Output fields are stable while out_valid & !out_ready (head not popped).

## Test plan
- Decode sweep, one word at a time with out_ready = 1:
  - 0x00500093 → dst 1, src1 0, imm 5, ALU_ADD, REG/IMM, reg_we 1.
  - 0x00309113 → ALU_SLL, imm 3.
  - 0xFFC12283 → ALU_LW, imm 0xFFFFFFFC, src1 2, dst 5, is_load 1.
  - 0x0000006F (jal x0) → ALU_JAL, reg_we 0.
- M-extension: 0x022081B3 with ENABLE_M = 1 → ALU_MUL, src1 1, src2 2, dst 3, reg_we 1. With ENABLE_M = 0 → illegal 1, reg_we 0.
- System and illegal: 0x00000073 → is_halt 1, reg_we 0. 0xFFFFFFFF → illegal 1, all other fields 0.
- Backpressure with DEPTH = 2, out_ready = 0:
  - two pushes → count 2, in_ready 0;
  - third word held, not lost;
  - out_ready = 1 for one cycle → first pc popped, third accepted the cycle after;
  - order is preserved across pointer wrap over 10 words.
- Flush with count = 2, and in_valid = 1 and out_ready = 1 in the flush cycle → next cycle count 0, out_valid 0. Neither the input word nor a pop is counted.
- Reset mid-stream: rst_n pulled low between edges with count = 1 → out_valid drops to 0 immediately and in_ready = 1. After release, a push is seen on the outputs one cycle later.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV32M decode stage: combinational decode of the incoming word into a
// DEPTH-entry FIFO of decoded records, with flush for branch redirect.
module decode_stage #(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_ir,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [4:0]                 srcreg1_num,
  output logic [4:0]                 srcreg2_num,
  output logic [4:0]                 dstreg_num,
  output logic [31:0]                imm,
  output logic [5:0]                 alucode,
  output logic [1:0]                 aluop1_type,
  output logic [1:0]                 aluop2_type,
  output logic                       reg_we,
  output logic                       is_load,
  output logic                       is_store,
  output logic                       is_halt,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [5:0] ALU_LUI = 6'd0, ALU_JAL = 6'd1, ALU_JALR = 6'd2,
    ALU_BEQ = 6'd3, ALU_BNE = 6'd4, ALU_BLT = 6'd5, ALU_BGE = 6'd6,
    ALU_BLTU = 6'd7, ALU_BGEU = 6'd8, ALU_LB = 6'd9, ALU_LH = 6'd10,
    ALU_LW = 6'd11, ALU_LBU = 6'd12, ALU_LHU = 6'd13, ALU_SB = 6'd14,
    ALU_SH = 6'd15, ALU_SW = 6'd16, ALU_ADD = 6'd17, ALU_SUB = 6'd18,
    ALU_XOR = 6'd19, ALU_OR = 6'd20, ALU_AND = 6'd21, ALU_SLT = 6'd22,
    ALU_SLTU = 6'd23, ALU_SLL = 6'd24, ALU_SRL = 6'd25, ALU_SRA = 6'd26,
    ALU_MUL = 6'd27, ALU_MULH = 6'd28, ALU_MULHSU = 6'd29, ALU_MULHU = 6'd30,
    ALU_DIV = 6'd31, ALU_DIVU = 6'd32, ALU_REM = 6'd33, ALU_REMU = 6'd34,
    ALU_NOP = 6'd63;

  localparam logic [1:0] OP_NONE = 2'd0, OP_REG = 2'd1, OP_IMM = 2'd2, OP_PC = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        illegal;
  } entry_t;

  entry_t             dec_p0;
  entry_t             mem [DEPTH];
  entry_t             head_p1;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               push, pop;

  // Stage 0: combinational decode of the incoming word
  always_comb begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wb, ill;
    opc   = in_ir[6:0];
    f3    = in_ir[14:12];
    f7    = in_ir[31:25];
    imm_i = {{20{in_ir[31]}}, in_ir[31:20]};
    imm_s = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
    imm_b = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
    imm_u = {in_ir[31:12], 12'b0};
    imm_j = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
    wb     = 1'b0;
    ill    = 1'b0;
    dec_p0 = '0;
    dec_p0.pc = in_pc;
    unique case (opc)
      7'b0110111: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.imm = imm_u;
        dec_p0.alucode = ALU_LUI; dec_p0.op1 = OP_NONE; dec_p0.op2 = OP_IMM;
      end
      7'b0010111: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.imm = imm_u;
        dec_p0.alucode = ALU_ADD; dec_p0.op1 = OP_IMM; dec_p0.op2 = OP_PC;
      end
      7'b1101111: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.imm = imm_j;
        dec_p0.alucode = ALU_JAL; dec_p0.op1 = OP_NONE; dec_p0.op2 = OP_PC;
      end
      7'b1100111: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.rs1 = in_ir[19:15];
        dec_p0.imm = imm_i; dec_p0.alucode = ALU_JALR;
        dec_p0.op1 = OP_REG; dec_p0.op2 = OP_PC;
      end
      7'b1100011: begin
        dec_p0.rs1 = in_ir[19:15]; dec_p0.rs2 = in_ir[24:20]; dec_p0.imm = imm_b;
        dec_p0.op1 = OP_REG; dec_p0.op2 = OP_REG;
        case (f3)
          3'b000:  dec_p0.alucode = ALU_BEQ;
          3'b001:  dec_p0.alucode = ALU_BNE;
          3'b100:  dec_p0.alucode = ALU_BLT;
          3'b101:  dec_p0.alucode = ALU_BGE;
          3'b110:  dec_p0.alucode = ALU_BLTU;
          3'b111:  dec_p0.alucode = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.rs1 = in_ir[19:15];
        dec_p0.imm = imm_i; dec_p0.is_load = 1'b1;
        dec_p0.op1 = OP_REG; dec_p0.op2 = OP_IMM;
        case (f3)
          3'b000:  dec_p0.alucode = ALU_LB;
          3'b001:  dec_p0.alucode = ALU_LH;
          3'b010:  dec_p0.alucode = ALU_LW;
          3'b100:  dec_p0.alucode = ALU_LBU;
          3'b101:  dec_p0.alucode = ALU_LHU;
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_p0.rs1 = in_ir[19:15]; dec_p0.rs2 = in_ir[24:20]; dec_p0.imm = imm_s;
        dec_p0.is_store = 1'b1; dec_p0.op1 = OP_REG; dec_p0.op2 = OP_REG;
        case (f3)
          3'b000:  dec_p0.alucode = ALU_SB;
          3'b001:  dec_p0.alucode = ALU_SH;
          3'b010:  dec_p0.alucode = ALU_SW;
          default: ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.rs1 = in_ir[19:15];
        dec_p0.imm = imm_i; dec_p0.op1 = OP_REG; dec_p0.op2 = OP_IMM;
        case (f3)
          3'b000: dec_p0.alucode = ALU_ADD;
          3'b010: dec_p0.alucode = ALU_SLT;
          3'b011: dec_p0.alucode = ALU_SLTU;
          3'b100: dec_p0.alucode = ALU_XOR;
          3'b110: dec_p0.alucode = ALU_OR;
          3'b111: dec_p0.alucode = ALU_AND;
          3'b001: begin dec_p0.alucode = ALU_SLL; dec_p0.imm = {27'b0, in_ir[24:20]}; end
          default: begin
            dec_p0.alucode = in_ir[30] ? ALU_SRA : ALU_SRL;
            dec_p0.imm     = {27'b0, in_ir[24:20]};
          end
        endcase
      end
      7'b0110011: begin
        wb = 1'b1; dec_p0.rd = in_ir[11:7]; dec_p0.rs1 = in_ir[19:15];
        dec_p0.rs2 = in_ir[24:20]; dec_p0.op1 = OP_REG; dec_p0.op2 = OP_REG;
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec_p0.alucode = in_ir[30] ? ALU_SUB : ALU_ADD;
            3'b001:  dec_p0.alucode = ALU_SLL;
            3'b010:  dec_p0.alucode = ALU_SLT;
            3'b011:  dec_p0.alucode = ALU_SLTU;
            3'b100:  dec_p0.alucode = ALU_XOR;
            3'b101:  dec_p0.alucode = in_ir[30] ? ALU_SRA : ALU_SRL;
            3'b110:  dec_p0.alucode = ALU_OR;
            default: dec_p0.alucode = ALU_AND;
          endcase
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          case (f3)
            3'b000:  dec_p0.alucode = ALU_MUL;
            3'b001:  dec_p0.alucode = ALU_MULH;
            3'b010:  dec_p0.alucode = ALU_MULHSU;
            3'b011:  dec_p0.alucode = ALU_MULHU;
            3'b100:  dec_p0.alucode = ALU_DIV;
            3'b101:  dec_p0.alucode = ALU_DIVU;
            3'b110:  dec_p0.alucode = ALU_REM;
            default: dec_p0.alucode = ALU_REMU;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      7'b1110011: begin
        // Only ECALL and EBREAK are recognised; both stop the core
        if (in_ir[31:7] == 25'h0 || in_ir[31:7] == 25'h2000) begin
          dec_p0.is_halt = 1'b1; dec_p0.imm = imm_i; dec_p0.alucode = ALU_NOP;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    dec_p0.reg_we = wb && (in_ir[11:7] != 5'd0);
    if (ill) begin
      dec_p0         = '0;
      dec_p0.pc      = in_pc;
      dec_p0.illegal = 1'b1;
    end
  end

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Stage 1: FIFO of decoded records
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_p0;
  end

  assign head_p1     = out_valid ? mem[rd_ptr] : '0;
  assign out_pc      = head_p1.pc;
  assign srcreg1_num = head_p1.rs1;
  assign srcreg2_num = head_p1.rs2;
  assign dstreg_num  = head_p1.rd;
  assign imm         = head_p1.imm;
  assign alucode     = head_p1.alucode;
  assign aluop1_type = head_p1.op1;
  assign aluop2_type = head_p1.op2;
  assign reg_we      = head_p1.reg_we;
  assign is_load     = head_p1.is_load;
  assign is_store    = head_p1.is_store;
  assign is_halt     = head_p1.is_halt;
  assign illegal     = head_p1.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-derived expected records are queued
// on every accepted push and compared against the head on every pop.
module tb_decode_stage;
  localparam logic [5:0] ALU_LUI = 6'd0, ALU_JAL = 6'd1, ALU_LW = 6'd11,
    ALU_ADD = 6'd17, ALU_SLL = 6'd24, ALU_MUL = 6'd27, ALU_NOP = 6'd63;
  localparam logic [1:0] T_NONE = 2'd0, T_REG = 2'd1, T_IMM = 2'd2, T_PC = 2'd3;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = '0, in_pc = '0;
  logic in_ready, out_valid, reg_we, is_load, is_store, is_halt, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0] srcreg1_num, srcreg2_num, dstreg_num;
  logic [5:0] alucode;
  logic [1:0] aluop1_type, aluop2_type, count;
  logic n_in_ready, n_out_valid, n_reg_we, n_is_load, n_is_store, n_is_halt, n_illegal;
  logic [31:0] n_out_pc, n_imm;
  logic [4:0] n_rs1, n_rs2, n_rd;
  logic [5:0] n_alucode;
  logic [1:0] n_op1, n_op2, n_count;

  decode_stage #(.DEPTH(2), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num),
    .dstreg_num(dstreg_num), .imm(imm), .alucode(alucode), .aluop1_type(aluop1_type),
    .aluop2_type(aluop2_type), .reg_we(reg_we), .is_load(is_load), .is_store(is_store),
    .is_halt(is_halt), .illegal(illegal), .count(count));

  decode_stage #(.DEPTH(2), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .srcreg1_num(n_rs1), .srcreg2_num(n_rs2),
    .dstreg_num(n_rd), .imm(n_imm), .alucode(n_alucode), .aluop1_type(n_op1),
    .aluop2_type(n_op2), .reg_we(n_reg_we), .is_load(n_is_load), .is_store(n_is_store),
    .is_halt(n_is_halt), .illegal(n_illegal), .count(n_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  s1, s2, d;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  t1, t2;
    logic        we, ld, st, halt, ill;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t cur_exp;

  function automatic exp_t mk(logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                              logic [31:0] im, logic [5:0] alu, logic [1:0] t1,
                              logic [1:0] t2, logic we, logic ld, logic st,
                              logic halt, logic ill);
    exp_t e;
    e = '{pc: 32'h0, s1: s1, s2: s2, d: d, imm: im, alu: alu, t1: t1, t2: t2,
          we: we, ld: ld, st: st, halt: halt, ill: ill};
    return e;
  endfunction

  function automatic exp_t obs();
    return {out_pc, srcreg1_num, srcreg2_num, dstreg_num, imm, alucode,
            aluop1_type, aluop2_type, reg_we, is_load, is_store, is_halt, illegal};
  endfunction

  function automatic logic [31:0] addi_ir(int k);
    logic [11:0] v;
    v = 12'(k);
    return {v, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  // One clock: score any pop/push that the upcoming edge will perform
  task automatic step();
    bit   acc, pp;
    exp_t e;
    acc = in_valid && in_ready && !flush;
    pp  = out_valid && out_ready && !flush;
    if (pp) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pop: got pc=%h, required no output", out_pc);
      end else begin
        e = sbq.pop_front();
        if (obs() !== e) begin
          failures++;
          $display("FAIL sb_head: got %h, required %h", obs(), e);
        end
      end
    end
    if (acc) begin
      e    = cur_exp;
      e.pc = in_pc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] ir, logic [31:0] pc, exp_t e);
    in_valid = 1'b1;
    in_ir    = ir;
    in_pc    = pc;
    cur_exp  = e;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) step();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0} || obs() !== '0) begin
      failures++;
      $display("FAIL reset_state: got v=%b r=%b c=%0d f=%h, required v=0 r=1 c=0 f=0",
               out_valid, in_ready, count, obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_decode();
    logic [31:0] irs [8];
    exp_t        ex  [8];
    irs[0] = 32'h00500093; ex[0] = mk(0, 0, 1, 32'd5, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0);
    irs[1] = 32'h00309113; ex[1] = mk(1, 0, 2, 32'd3, ALU_SLL, T_REG, T_IMM, 1, 0, 0, 0, 0);
    irs[2] = 32'hFFC12283; ex[2] = mk(2, 0, 5, 32'hFFFFFFFC, ALU_LW, T_REG, T_IMM, 1, 1, 0, 0, 0);
    irs[3] = 32'h0000006F; ex[3] = mk(0, 0, 0, 32'd0, ALU_JAL, T_NONE, T_PC, 0, 0, 0, 0, 0);
    irs[4] = 32'h00000013; ex[4] = mk(0, 0, 0, 32'd0, ALU_ADD, T_REG, T_IMM, 0, 0, 0, 0, 0);
    irs[5] = 32'h123450B7; ex[5] = mk(0, 0, 1, 32'h12345000, ALU_LUI, T_NONE, T_IMM, 1, 0, 0, 0, 0);
    irs[6] = 32'h00000073; ex[6] = mk(0, 0, 0, 32'd0, ALU_NOP, T_NONE, T_NONE, 0, 0, 0, 1, 0);
    irs[7] = 32'h00100073; ex[7] = mk(0, 0, 0, 32'd1, ALU_NOP, T_NONE, T_NONE, 0, 0, 0, 1, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(irs[i], 32'h1000 + 32'(i * 4), ex[i]);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(i * 4)) begin
        failures++;
        $display("FAIL decode_latency[%0d]: got v=%b pc=%h, required v=1 pc=%h",
                 i, out_valid, out_pc, 32'h1000 + 32'(i * 4));
      end
      in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] irs [3];
    irs[0] = 32'hFFFFFFFF;
    irs[1] = 32'h00002063;
    irs[2] = 32'h0000B003;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(irs[i], 32'h2000 + 32'(i * 4), mk(0, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1));
      step();
      in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_m_ext();
    exp_t ill_e;
    out_ready = 1'b1;
    drive(32'h022081B3, 32'h3000, mk(1, 2, 3, 0, ALU_MUL, T_REG, T_REG, 1, 0, 0, 0, 0));
    step();
    ill_e    = mk(0, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
    ill_e.pc = 32'h3000;
    checks++;
    if ({n_out_valid, n_in_ready, n_count} !== {1'b1, 1'b1, 2'd1} ||
        {n_out_pc, n_rs1, n_rs2, n_rd, n_imm, n_alucode, n_op1, n_op2, n_reg_we,
         n_is_load, n_is_store, n_is_halt, n_illegal} !== ill_e) begin
      failures++;
      $display("FAIL m_disabled_illegal: got v=%b ill=%b we=%b alu=%0d, required v=1 ill=1 we=0 alu=0",
               n_out_valid, n_illegal, n_reg_we, n_alucode);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(addi_ir(1), 32'h300, mk(0, 0, 1, 32'd1, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    drive(addi_ir(2), 32'h304, mk(0, 0, 1, 32'd2, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got count=%0d in_ready=%b, required count=2 in_ready=0",
               count, in_ready);
    end
    drive(addi_ir(3), 32'h308, mk(0, 0, 1, 32'd3, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    step();
    checks++;
    if (count !== 2'd2 || out_pc !== 32'h300 || imm !== 32'd1) begin
      failures++;
      $display("FAIL bp_hold: got count=%0d pc=%h imm=%h, required count=2 pc=300 imm=1",
               count, out_pc, imm);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 2'd1 || out_pc !== 32'h304) begin
      failures++;
      $display("FAIL bp_pop_refuse: got count=%0d pc=%h, required count=1 pc=304", count, out_pc);
    end
    step();
    checks++;
    if (count !== 2'd2) begin
      failures++;
      $display("FAIL bp_third_accept: got count=%0d, required 2", count);
    end
    drain();
    checks++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got pending=%0d v=%b, required 0 0", sbq.size(), out_valid);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    for (int cyc = 0; cyc < 200 && sent < 10; cyc++) begin
      bit acc;
      drive(addi_ir(40 + sent), 32'h400 + 32'(sent * 4),
            mk(0, 0, 1, 32'(40 + sent), ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
      out_ready = 1'($urandom_range(0, 1));
      acc = in_ready;
      step();
      if (acc) sent++;
    end
    drain();
    checks++;
    if (sent != 10 || sbq.size() != 0 || count !== 2'd0) begin
      failures++;
      $display("FAIL wrap_order: got sent=%0d pending=%0d count=%0d, required 10 0 0",
               sent, sbq.size(), count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(addi_ir(80 + i), 32'h600 + 32'(i * 4),
            mk(0, 0, 1, 32'(80 + i), ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
      step();
      checks++;
      if (in_ready !== 1'b1 || count !== 2'd1 || out_pc !== 32'h600 + 32'(i * 4)) begin
        failures++;
        $display("FAIL b2b[%0d]: got r=%b count=%0d pc=%h, required r=1 count=1 pc=%h",
                 i, in_ready, count, out_pc, 32'h600 + 32'(i * 4));
      end
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(addi_ir(7), 32'h700, mk(0, 0, 1, 32'd7, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    drive(addi_ir(8), 32'h704, mk(0, 0, 1, 32'd8, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    drive(addi_ir(9), 32'h708, mk(0, 0, 1, 32'd9, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs() !== '0) begin
      failures++;
      $display("FAIL flush_clear: got count=%0d v=%b r=%b f=%h, required 0 0 1 0",
               count, out_valid, in_ready, obs());
    end
    sbq.delete();
    out_ready = 1'b1;
    drive(addi_ir(10), 32'h70C, mk(0, 0, 1, 32'd10, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(addi_ir(11), 32'h500, mk(0, 0, 1, 32'd11, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || obs() !== '0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b r=%b count=%0d f=%h, required 0 1 0 0",
               out_valid, in_ready, count, obs());
    end
    sbq.delete();
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(addi_ir(12), 32'h504, mk(0, 0, 1, 32'd12, ALU_ADD, T_REG, T_IMM, 1, 0, 0, 0, 0));
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h504) begin
      failures++;
      $display("FAIL reset_first_push: got v=%b pc=%h, required v=1 pc=504", out_valid, out_pc);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_m_ext();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
